// File: rtl/fir_mac_sequencer.sv
// -----------------------------------------------------------------------------
// fir_mac_sequencer
// Time-multiplexed FIR engine. It accepts one signed sample per handshake,
// shifts it into an N-deep delay line and then steps a single multiply-
// accumulate across all N taps. It presents one full-precision output per
// accepted sample. Coefficients live in a runtime-writable bank.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (wins over every other input)
//   s_valid    input sample valid
//   s_ready    engine can accept a sample (high only in IDLE)
//   s_x        signed input sample
//   m_valid    output valid (high only in OUT)
//   m_ready    consumer accepts output
//   m_y        signed full-precision filter output
//   coef_we    coefficient write strobe (honoured only in IDLE, no handshake)
//   coef_addr  tap index of the coefficient write
//   coef_data  signed coefficient value
//   flush      zero the delay line and accumulator, abort, return to IDLE
//   busy       high whenever the FSM is not in IDLE
//   dbg_state  raw FSM state (0 IDLE, 1 MAC, 2 OUT) for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A source holds valid and its data until that edge. The engine never
// overlaps input and output, so s_ready and m_valid are never 1 together.
// -----------------------------------------------------------------------------
module fir_mac_sequencer #(
  parameter int N       = 4,
  parameter int WIDTH_X = 4,
  parameter int WIDTH_B = 4,
  parameter int WIDTH_Y = WIDTH_X + WIDTH_B + $clog2(N)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic signed [WIDTH_X-1:0] s_x,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic signed [WIDTH_Y-1:0] m_y,
  input  logic                      coef_we,
  input  logic [$clog2(N)-1:0]      coef_addr,
  input  logic signed [WIDTH_B-1:0] coef_data,
  input  logic                      flush,
  output logic                      busy,
  output logic [1:0]                dbg_state
);

  localparam int AW = $clog2(N);
  localparam int WP = WIDTH_X + WIDTH_B;

  // One extra bit so an out-of-range address can be recognised for any N.
  localparam logic [AW:0]   N_EXT  = (AW+1)'(N);
  localparam logic [AW-1:0] K_LAST = AW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state;

  logic signed [WIDTH_X-1:0] line [N];
  logic signed [WIDTH_B-1:0] coef [N];
  logic signed [WIDTH_Y-1:0] acc;
  logic [AW-1:0]             k;

  logic signed [WP-1:0]      prod;
  logic signed [WIDTH_Y-1:0] prod_ext;
  logic signed [WIDTH_Y-1:0] sum;

  // The single shared multiplier. The product is sign-extended to the
  // output width before it is accumulated, so the sum can never wrap.
  always_comb begin
    prod     = line[k] * coef[k];
    prod_ext = {{(WIDTH_Y-WP){prod[WP-1]}}, prod};
    sum      = acc + prod_ext;
  end

  assign s_ready   = (state == IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      k       <= '0;
      m_valid <= 1'b0;
      m_y     <= '0;
      for (int i = 0; i < N; i++) begin
        line[i] <= '0;
        coef[i] <= '0;
      end
    end else begin
      // A write is taken only when the engine is idle. If a sample arrives
      // in the same cycle, the sample has priority and the write is dropped.
      if (state == IDLE && coef_we && !s_valid && ({1'b0, coef_addr} < N_EXT))
        coef[coef_addr] <= coef_data;

      if (flush) begin
        // Abort. History and partial sum are cleared. Coefficients are kept.
        for (int i = 0; i < N; i++) line[i] <= '0;
        acc     <= '0;
        k       <= '0;
        m_valid <= 1'b0;
        state   <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (s_valid) begin
              line[0] <= s_x;
              for (int i = 1; i < N; i++) line[i] <= line[i-1];
              acc   <= '0;
              k     <= '0;
              state <= MAC;
            end
          end
          MAC: begin
            acc <= sum;
            k   <= k + 1'b1;
            if (k == K_LAST) begin
              m_y     <= sum;
              m_valid <= 1'b1;
              k       <= '0;
              state   <= OUT;
            end
          end
          OUT: begin
            if (m_ready) begin
              m_valid <= 1'b0;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for fir_mac_sequencer (N=4, 4-bit samples and coefficients,
// 10-bit output). Directed vectors use hand-computed outputs. A short random
// soak follows, with its outputs predicted by a small reference model.
// -----------------------------------------------------------------------------
module tb_fir_mac_sequencer;

  localparam int N  = 4;
  localparam int WX = 4;
  localparam int WB = 4;
  localparam int WY = 10;
  localparam int TO = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 s_valid;
  logic                 s_ready;
  logic signed [WX-1:0] s_x;
  logic                 m_valid;
  logic                 m_ready;
  logic signed [WY-1:0] m_y;
  logic                 coef_we;
  logic [1:0]           coef_addr;
  logic signed [WB-1:0] coef_data;
  logic                 flush;
  logic                 busy;
  logic [1:0]           dbg_state;

  fir_mac_sequencer #(.N(N), .WIDTH_X(WX), .WIDTH_B(WB), .WIDTH_Y(WY)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_x       (s_x),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_y       (m_y),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .flush     (flush),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic signed [WY-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int acc_cnt = 0;
  int out_cnt = 0;
  int hist [N];
  int bm   [N];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: shift a sample into the history, queue the expected y.
  task automatic model_push(input int x);
    int y;
    for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    y = 0;
    for (int i = 0; i < N; i++) y += bm[i] * hist[i];
    exp_q.push_back(WY'(y));
  endtask

  // ---------------- driver tasks (entered and left on a negedge) ----------
  task automatic send(input int x);
    int g = 0;
    while (!s_ready && g < TO) begin
      @(negedge clk);
      g++;
    end
    if (g >= TO) check_eq("send_timeout", g, 0);
    s_valid = 1'b1;
    s_x     = x[WX-1:0];
    @(negedge clk);
    s_valid = 1'b0;
    acc_cnt++;
  endtask

  task automatic write_coef(input int addr, input int data);
    coef_we   = 1'b1;
    coef_addr = addr[1:0];
    coef_data = data[WB-1:0];
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  task automatic write_bank(input int b0, input int b1, input int b2, input int b3);
    write_coef(0, b0);
    write_coef(1, b1);
    write_coef(2, b2);
    write_coef(3, b3);
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Called on the negedge right after a handshake. It waits for m_valid and
  // checks latency and value. The latency counts the edge at which the
  // consumer first captures m_valid.
  task automatic wait_valid();
    int e = 0;
    while (!m_valid && e < TO) begin
      @(negedge clk);
      e++;
    end
    check_eq("latency", e + 1, N + 1);
    if (m_valid) out_cnt++;
    if (exp_q.size() == 0) check_eq("exp_q_empty", 0, 1);
    else check_eq("m_y", m_y, exp_q.pop_front());
  endtask

  // Wait for an output, then consume it. The engine is back in IDLE on return.
  task automatic recv(input bit rnd);
    int g = 0;
    wait_valid();
    while (m_valid && g < TO) begin
      if (rnd) m_ready = ($urandom_range(0, 1) == 1);
      else     m_ready = 1'b1;
      @(negedge clk);
      g++;
    end
    if (g >= TO) check_eq("consume_timeout", g, 0);
    m_ready = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; s_valid = 1'b0; s_x = '0; m_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_eq("rst_s_ready", s_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_m_y", m_y, 0);
    check_eq("rst_state", dbg_state, 0);

    // Impulse response: B = {1,2,3,4}
    write_bank(1, 2, 3, 4);
    exp_q.push_back(1); send(1); recv(0);
    exp_q.push_back(2); send(0); recv(0);
    exp_q.push_back(3); send(0); recv(0);
    exp_q.push_back(4); send(0); recv(0);
    exp_q.push_back(0); send(0); recv(0);

    // Negative extreme: every B = -8, every x = -8
    write_bank(-8, -8, -8, -8);
    exp_q.push_back(64);  send(-8); recv(0);
    exp_q.push_back(128); send(-8); recv(0);
    exp_q.push_back(192); send(-8); recv(0);
    exp_q.push_back(256); send(-8); recv(0);
    exp_q.push_back(256); send(-8); recv(0);

    // Coefficient write gating
    flush_pulse();
    write_bank(1, 2, 3, 4);
    exp_q.push_back(2);                   // write during MAC is ignored: 1*2
    send(2);
    fork
      write_coef(0, 5);
      recv(0);
    join
    write_coef(0, 5);                     // same write in IDLE is taken
    exp_q.push_back(19);                  // 5*3 + 2*2
    send(3); recv(0);
    // Sample and write in the same cycle: sample wins, B[1] stays 2
    exp_q.push_back(17);                  // 5*1 + 2*3 + 3*2
    s_valid = 1'b1; s_x = 4'sd1;
    coef_we = 1'b1; coef_addr = 2'd1; coef_data = 4'sd7;
    @(negedge clk);
    s_valid = 1'b0; coef_we = 1'b0;
    recv(0);

    // Backpressure: history {0,1,3,2} -> 0 + 2 + 9 + 8 = 19
    m_ready = 1'b0;
    exp_q.push_back(19);
    send(0);
    wait_valid();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("bp_m_valid", m_valid, 1);
      check_eq("bp_m_y", m_y, 19);
      check_eq("bp_s_ready", s_ready, 0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_m_valid", m_valid, 0);
    check_eq("bp_release_s_ready", s_ready, 1);

    // Reset in the middle of MAC: result discarded, coefficients cleared
    send(1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_state", dbg_state, 0);
    check_eq("midrst_m_valid", m_valid, 0);
    check_eq("midrst_m_y", m_y, 0);
    check_eq("midrst_s_ready", s_ready, 1);
    exp_q.push_back(0);                   // all coefficients are 0 now
    send(5); recv(0);

    // Flush in the middle of MAC: history cleared, coefficients kept
    write_bank(1, 2, 3, 4);
    exp_q.push_back(17);                  // history {7,5,0,0}: 7 + 10
    send(7); recv(0);
    send(-2);
    @(negedge clk);
    flush_pulse();
    check_eq("flush_state", dbg_state, 0);
    check_eq("flush_m_valid", m_valid, 0);
    // flush beats a simultaneous sample, which is not stored
    s_valid = 1'b1; flush = 1'b1; s_x = 4'sd6;
    check_eq("flush_s_ready", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0; flush = 1'b0;
    check_eq("flush_no_start", busy, 0);
    exp_q.push_back(3);                   // 1*3, history otherwise zero
    send(3); recv(0);

    // Random soak against the reference model
    flush_pulse();
    for (int i = 0; i < N; i++) hist[i] = 0;
    bm[0] = 1; bm[1] = 2; bm[2] = 3; bm[3] = 4;
    acc_cnt = 0;
    out_cnt = 0;
    for (int n = 0; n < 500; n++) begin
      int x;
      x = int'($urandom_range(0, 15)) - 8;
      model_push(x);
      send(x);
      recv(1);
    end
    check_eq("soak_count", out_cnt, acc_cnt);
    check_eq("soak_q_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Time-multiplexed FIR engine controller. It accepts one signed sample at a time over a valid/ready stream and sequences a single multiply-accumulate unit across N taps held in a sample delay line and a runtime-loadable coefficient bank. It emits one full-precision output per accepted sample. It sits between a sample source and a downstream consumer, replacing the fully parallel fir_filter where area matters more than throughput.

Parameters:
N, 4, number of taps (>=2)
WIDTH_X, 4, signed sample width
WIDTH_B, 4, signed coefficient width
WIDTH_Y, WIDTH_X+WIDTH_B+$clog2(N), signed output width; default is full precision, no overflow

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
s_valid  in  1  input sample valid
s_ready  out  1  engine can accept a sample
s_x  in  WIDTH_X  signed input sample
m_valid  out  1  output valid
m_ready  in  1  consumer accepts output
m_y  out  WIDTH_Y  signed filter output
coef_we  in  1  coefficient write strobe
coef_addr  in  $clog2(N)  tap index k
coef_data  in  WIDTH_B  signed coefficient B[k]
flush  in  1  zero delay line, abort current sample
busy  out  1  high in any state other than IDLE

Behaviour:
- Function: y[n] = sum over k=0..N-1 of B[k]*x[n-k], where x[n] is the n-th accepted sample. Pre-history samples are 0. Products are sign-extended to WIDTH_Y before accumulation.
- Reset (rst=1 at an edge): state=IDLE, delay line all 0, all coefficients 0, acc=0, tap counter=0, m_valid=0, m_y=0. Outputs: s_ready=1 after reset, busy=0. Reset wins over every other input, including mid-MAC, and any in-flight result is discarded.
- FSM IDLE / MAC / OUT:
  - IDLE: s_ready=1. On s_valid, the handshake fires: the delay line shifts (line[0]<=s_x, line[k]<=line[k-1]), acc<=0, k<=0, next state MAC.
  - MAC: s_ready=0. Runs exactly N cycles. Each cycle: acc<=acc+line[k]*coef[k], k<=k+1. When k==N-1, next state OUT and m_y<=final sum.
  - OUT: m_valid=1, m_y is stable. Stays in OUT until m_ready=1, then m_valid<=0 and next state IDLE.
- Latency: handshake at edge t produces m_valid=1 from edge t+N+1. Max throughput is one sample per N+2 cycles with m_ready held high. There is no overlap; s_ready is never 1 while m_valid=1.
- m_y and m_valid hold while m_ready=0; m_y may be any value while m_valid=0.
- Coefficient write: coef_we is accepted only in IDLE, and only when no s_valid handshake occurs in the same cycle (the sample wins; the write is dropped). Writes in MAC or OUT are ignored. coef_addr>=N is ignored. A written coefficient is used from the next accepted sample on.
- flush (lower priority than rst): in any state, zeroes the delay line and acc, sets m_valid<=0, state<=IDLE. If s_valid is asserted in IDLE in the same cycle, flush wins: s_ready still reads 1, but the sample is NOT stored. The source must treat s_valid and flush as mutually exclusive. Coefficients are retained.
- busy = (state != IDLE).

Test Plan:
- Impulse: B={1,2,3,4}; feed 1,0,0,0,0 with m_ready=1 -> m_y sequence 1,2,3,4,0; each m_valid rises exactly N+1=5 cycles after its handshake.
- Negative extreme: all B=-8; feed five samples of x=-8 -> m_y 64,128,192,256,256 with no wrap (WIDTH_Y=10).
- Backpressure: hold m_ready=0 for 6 cycles in OUT -> m_valid=1, m_y constant, s_ready=0 throughout; the first m_ready=1 edge gives m_valid=0 and s_ready=1 next cycle.
- Coef write gating: write B[0]=5 during MAC -> ignored and the result uses the old B[0]; the same write in IDLE -> the next output reflects 5*x[n].
- Mid-operation reset/flush: assert rst at MAC cycle 2 -> next cycle state IDLE, m_valid=0, coefficients 0, and the next output is 0. Repeat with flush -> coefficients kept, history zero, and input 3 with B={1,2,3,4} gives y=3.
- Random soak: 500 random samples and random m_ready; compare against a software model of y[n] and check the count of outputs equals the count of accepted samples.
